// File: rtl/spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_pkg : frame geometry and controller states shared with the   |
// |           SPI register-write peripheral.                 rev 1.0 |
// +------------------------------------------------------------------+
package spi_pkg;
   localparam int   FRAME_W  = 16;
   localparam int   ADDR_W   = 7;
   localparam int   DATA_W   = 8;
   localparam logic RW_WRITE = 1'b1;
   localparam int   MAX_ADDR = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_GAP   = 3'd4
   } ctrl_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage
`default_nettype wire

// File: rtl/spi_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_req_if : host-side register request handshake.       rev 1.0 |
// +------------------------------------------------------------------+
interface spi_req_if;
   import spi_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_rw;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic              busy;
   logic              done;

   modport master (
      output req_valid, req_rw, req_addr, req_data,
      input  req_ready, busy, done
   );

   modport slave (
      input  req_valid, req_rw, req_addr, req_data,
      output req_ready, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/spi_tick_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_tick_counter : loadable down-counter, flags terminal count.  |
// |                                                          rev 1.0 |
// +------------------------------------------------------------------+
module spi_tick_counter #(
   parameter int WIDTH = 4
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_value,
   output logic                  o_tc
);
   logic [WIDTH-1:0] r_count;

   // Loading N-1 gives exactly N cycles before the terminal-count cycle ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_tc = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/spi_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_controller : SPI mode-0 initiator, one 16-bit {rw,addr,data} |
// |                  frame per accepted request.             rev 1.0 |
// +------------------------------------------------------------------+
module spi_controller
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 8
) (
   input  wire logic clk,
   input  wire logic rst_n,
   spi_req_if.slave  req,
   output logic      SCLK,
   output logic      COPI,
   output logic      nCS
);
   localparam int               CNT_W       = $clog2(max_int(CLK_DIV, CS_GAP) + 1);
   localparam logic [CNT_W-1:0] c_HALF_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] c_GAP_LOAD  = CNT_W'(CS_GAP - 1);

   ctrl_state_t        r_state;
   logic [FRAME_W-1:0] r_shreg;
   logic [3:0]         r_bit_cnt;
   logic               r_sclk;
   logic               r_ncs;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_load;
   logic               w_tc;
   logic [CNT_W-1:0]   w_load_val;

   assign w_accept   = (r_state == ST_IDLE) && req.req_valid;
   assign w_load     = (r_state == ST_IDLE) ? w_accept : w_tc;
   assign w_load_val = ((r_state == ST_LOW) && (r_bit_cnt == 4'd15)) ? c_GAP_LOAD : c_HALF_LOAD;

   spi_tick_counter #(.WIDTH(CNT_W)) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_tc    (w_tc)
   );

   // COPI is the shift register MSB; the final shift at frame end leaves it zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_sclk    <= 1'b0;
         r_ncs     <= 1'b1;
         r_ready   <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_bit_cnt <= '0;
               if (w_accept) begin
                  r_shreg <= {req.req_rw, req.req_addr, req.req_data};
                  r_ncs   <= 1'b0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_tc) begin
                  r_sclk  <= 1'b1;
                  r_state <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (w_tc) begin
                  r_sclk  <= 1'b0;
                  r_state <= ST_LOW;
                  if (r_bit_cnt != 4'd15) begin
                     r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                  end
               end
            end
            ST_LOW: begin
               if (w_tc) begin
                  if (r_bit_cnt == 4'd15) begin
                     r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                     r_ncs   <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_GAP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     r_sclk    <= 1'b1;
                     r_state   <= ST_HIGH;
                  end
               end
            end
            ST_GAP: begin
               if (w_tc) begin
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign SCLK          = r_sclk;
   assign COPI          = r_shreg[FRAME_W-1];
   assign nCS           = r_ncs;
   assign req.req_ready = r_ready;
   assign req.busy      = r_busy;
   assign req.done      = r_done;
endmodule
`default_nettype wire
